// File: rtl/counter_mod_step_if.sv
// Control/status bundle for counter_mod_step.
interface counter_mod_step_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              load_n;
  logic              ce;
  logic              up_down;
  logic              sat_mode;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  data_load;
  logic              clr_sticky;
  logic [WIDTH-1:0]  count_out;
  logic              max_count;
  logic              zero;
  logic              wrap_evt;
  logic              ovf_sticky;

  // Driver side: sources controls, observes counter status.
  modport master (
    output load_n, ce, up_down, sat_mode, step, limit, data_load, clr_sticky,
    input  count_out, max_count, zero, wrap_evt, ovf_sticky
  );

  // Counter side.
  modport slave (
    input  load_n, ce, up_down, sat_mode, step, limit, data_load, clr_sticky,
    output count_out, max_count, zero, wrap_evt, ovf_sticky
  );
endinterface

// File: rtl/counter_mod_step.sv
// Up/down counter with programmable terminal value and step, wrap or
// saturate on bound crossing, one-cycle event pulse and sticky flag.
module counter_mod_step #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_mod_step_if.slave  bus
);
  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] r_count;
  logic             r_wrap_evt;
  logic             r_ovf_sticky;

  logic [WIDTH-1:0] w_next;
  logic             w_evt;
  logic [SUM_W-1:0] w_cnt_x;
  logic [SUM_W-1:0] w_step_x;
  logic [SUM_W-1:0] w_lim_x;
  logic [SUM_W-1:0] w_sum;

  // Widen operands so neither sum nor compare can truncate.
  assign w_cnt_x  = SUM_W'(r_count);
  assign w_step_x = SUM_W'(bus.step);
  assign w_lim_x  = SUM_W'(bus.limit);
  assign w_sum    = w_cnt_x + w_step_x;

  // Next count and bound-crossing event: load > count > hold.
  always_comb begin
    w_next = r_count;
    w_evt  = 1'b0;
    if (!bus.load_n) begin
      w_next = (bus.data_load <= bus.limit) ? bus.data_load : bus.limit;
    end else if (bus.ce && (bus.step != '0)) begin
      if (bus.up_down) begin
        if (w_sum <= w_lim_x) begin
          w_next = WIDTH'(w_sum);
        end else begin
          w_evt  = 1'b1;
          w_next = bus.sat_mode ? bus.limit : '0;
        end
      end else begin
        if (w_step_x <= w_cnt_x) begin
          w_next = WIDTH'(w_cnt_x - w_step_x);
        end else begin
          w_evt  = 1'b1;
          w_next = bus.sat_mode ? '0 : bus.limit;
        end
      end
    end
  end

  // Count, event pulse and sticky flag; a new event beats clr_sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_wrap_evt   <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_count    <= w_next;
      r_wrap_evt <= w_evt;
      if (w_evt) begin
        r_ovf_sticky <= 1'b1;
      end else if (bus.clr_sticky) begin
        r_ovf_sticky <= 1'b0;
      end
    end
  end

  assign bus.count_out  = r_count;
  assign bus.wrap_evt   = r_wrap_evt;
  assign bus.ovf_sticky = r_ovf_sticky;
  assign bus.max_count  = (r_count == bus.limit);
  assign bus.zero       = (r_count == '0);
endmodule

// File: tb/tb_counter_mod_step.sv
// Bench for counter_mod_step: arithmetic reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_counter_mod_step;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 4;

  logic clk;
  logic rst;

  counter_mod_step_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  counter_mod_step #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  bit chk_en;

  // Reference state expressed as plain integers.
  int m_count;
  bit m_evt;
  bit m_sticky;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model applies the counter rules to the inputs present now.
  task automatic cyc();
    int nxt;
    int st;
    int lim;
    int cnt;
    bit ev;
    bit sk;
    nxt = m_count;
    ev  = 1'b0;
    sk  = m_sticky;
    st  = int'(bus.step);
    lim = int'(bus.limit);
    cnt = m_count;
    if (rst) begin
      nxt = 0;
      sk  = 1'b0;
    end else begin
      if (!bus.load_n) begin
        nxt = (int'(bus.data_load) <= lim) ? int'(bus.data_load) : lim;
      end else if (bus.ce && st != 0) begin
        if (bus.up_down) begin
          if (cnt + st <= lim) nxt = cnt + st;
          else begin ev = 1'b1; nxt = bus.sat_mode ? lim : 0; end
        end else begin
          if (st <= cnt) nxt = cnt - st;
          else begin ev = 1'b1; nxt = bus.sat_mode ? 0 : lim; end
        end
      end
      if (ev) sk = 1'b1;
      else if (bus.clr_sticky) sk = 1'b0;
    end
    @(posedge clk);
    #1;
    m_count  = nxt;
    m_evt    = ev;
    m_sticky = sk;
    if (rst) chk_en = 1'b1;
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count",    int'(bus.count_out),  m_count);
      chk("m_wrap_evt", int'(bus.wrap_evt),   int'(m_evt));
      chk("m_sticky",   int'(bus.ovf_sticky), int'(m_sticky));
      chk("m_zero",     int'(bus.zero),       int'(m_count == 0));
      chk("m_max",      int'(bus.max_count),  int'(m_count == int'(bus.limit)));
    end
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    m_count  = 0;
    m_evt    = 1'b0;
    m_sticky = 1'b0;

    // Reset held two cycles while a load is requested.
    rst = 1'b1;
    bus.load_n = 1'b0; bus.data_load = 8'h55; bus.ce = 1'b0;
    bus.up_down = 1'b1; bus.sat_mode = 1'b0; bus.step = '0;
    bus.limit = 8'd9; bus.clr_sticky = 1'b0;
    cyc(); cyc();
    chk("rst_count", int'(bus.count_out), 0);
    chk("rst_zero", int'(bus.zero), 1);
    chk("rst_wrap", int'(bus.wrap_evt), 0);
    chk("rst_sticky", int'(bus.ovf_sticky), 0);
    chk("rst_max", int'(bus.max_count), 0);

    // Wrap up: limit 9, step 3.
    rst = 1'b0; bus.load_n = 1'b1; bus.ce = 1'b1; bus.step = 4'd3;
    cyc(); chk("wrap_3", int'(bus.count_out), 3);
    cyc(); chk("wrap_6", int'(bus.count_out), 6);
    cyc(); chk("wrap_9", int'(bus.count_out), 9);
    chk("wrap_9_max", int'(bus.max_count), 1);
    chk("wrap_9_evt", int'(bus.wrap_evt), 0);
    cyc(); chk("wrap_0", int'(bus.count_out), 0);
    chk("wrap_0_evt", int'(bus.wrap_evt), 1);
    chk("wrap_0_sticky", int'(bus.ovf_sticky), 1);
    bus.ce = 1'b0;
    cyc(); chk("wrap_evt_drop", int'(bus.wrap_evt), 0);

    // Saturate down: limit 200, load 5, step 4.
    bus.limit = 8'd200; bus.load_n = 1'b0; bus.data_load = 8'd5;
    cyc(); chk("sat_load5", int'(bus.count_out), 5);
    bus.load_n = 1'b1; bus.ce = 1'b1; bus.up_down = 1'b0;
    bus.step = 4'd4; bus.sat_mode = 1'b1;
    cyc(); chk("sat_1", int'(bus.count_out), 1);
    chk("sat_1_evt", int'(bus.wrap_evt), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sat_0", int'(bus.count_out), 0);
      chk("sat_0_evt", int'(bus.wrap_evt), 1);
    end
    bus.ce = 1'b0;

    // Load clamp.
    bus.limit = 8'd50; bus.load_n = 1'b0; bus.data_load = 8'd120;
    cyc(); chk("clamp_50", int'(bus.count_out), 50);
    chk("clamp_max", int'(bus.max_count), 1);
    chk("clamp_evt", int'(bus.wrap_evt), 0);
    bus.data_load = 8'd20;
    cyc(); chk("clamp_20", int'(bus.count_out), 20);

    // Limit lowered below the count.
    bus.limit = 8'd200; bus.data_load = 8'd100;
    cyc(); chk("low_load", int'(bus.count_out), 100);
    bus.load_n = 1'b1; bus.limit = 8'd60;
    cyc(); chk("low_hold", int'(bus.count_out), 100);
    bus.ce = 1'b1; bus.up_down = 1'b1; bus.step = 4'd0; bus.sat_mode = 1'b0;
    cyc(); chk("low_step0", int'(bus.count_out), 100);
    chk("low_step0_evt", int'(bus.wrap_evt), 0);
    bus.up_down = 1'b0; bus.step = 4'd15;
    cyc(); chk("low_down", int'(bus.count_out), 85);
    chk("low_down_evt", int'(bus.wrap_evt), 0);
    bus.up_down = 1'b1; bus.step = 4'd1;
    cyc(); chk("low_up_wrap", int'(bus.count_out), 0);
    chk("low_up_evt", int'(bus.wrap_evt), 1);

    // Sticky clear, then clear colliding with an event.
    bus.ce = 1'b0; bus.clr_sticky = 1'b1;
    cyc(); chk("clr_sticky", int'(bus.ovf_sticky), 0);
    bus.ce = 1'b1; bus.up_down = 1'b0;
    cyc(); chk("clr_vs_evt", int'(bus.ovf_sticky), 1);
    chk("clr_vs_evt_cnt", int'(bus.count_out), 60);
    bus.clr_sticky = 1'b0;

    // Reset mid-operation overrides load, count and clear.
    bus.up_down = 1'b1; bus.load_n = 1'b0; bus.data_load = 8'd33;
    bus.clr_sticky = 1'b1; rst = 1'b1;
    cyc(); chk("midrst_cnt", int'(bus.count_out), 0);
    chk("midrst_sticky", int'(bus.ovf_sticky), 0);
    rst = 1'b0; bus.load_n = 1'b1; bus.clr_sticky = 1'b0;

    // Mixed vectors, checked by the model only.
    for (int i = 0; i < 200; i++) begin
      bus.load_n     = ($urandom_range(0, 9) != 0);
      bus.ce         = ($urandom_range(0, 4) != 0);
      bus.up_down    = 1'($urandom_range(0, 1));
      bus.sat_mode   = 1'($urandom_range(0, 1));
      bus.step       = STEP_W'($urandom_range(0, 15));
      bus.data_load  = WIDTH'($urandom_range(0, 255));
      bus.clr_sticky = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.limit = WIDTH'($urandom_range(0, 255));
      cyc();
    end

    chk_en = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
